// File: rtl/gray_scale_pipe.sv
// Three-stage streaming RGB->gray converter (expand, weight, round/saturate) with a start/drain FSM.
// Optional runtime coefficients for mode 3 are enabled by defining CUSTOM_COEF_EN.
module gray_scale_pipe #(
    parameter int unsigned R_BITS    = 5,
    parameter int unsigned G_BITS    = 5,
    parameter int unsigned B_BITS    = 5,
    parameter int unsigned OUT_BITS  = 8,
    parameter int unsigned COEF_BITS = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               start_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [R_BITS+G_BITS+B_BITS-1:0]    in_px_rgb_i,
    input  logic [1:0]                         in_mode_i,
    input  logic                               in_last_i,
`ifdef CUSTOM_COEF_EN
    input  logic [COEF_BITS-1:0]               coef_r_i,
    input  logic [COEF_BITS-1:0]               coef_g_i,
    input  logic [COEF_BITS-1:0]               coef_b_i,
`endif
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [OUT_BITS-1:0]                out_px_gray_o,
    output logic                               out_last_o,
    output logic                               busy_o
);

    localparam int unsigned PX_W   = R_BITS + G_BITS + B_BITS;
    localparam int unsigned PROD_W = OUT_BITS + COEF_BITS;
    localparam int unsigned SUM_W  = PROD_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    // Rescale an 8-bit-reference weight to COEF_BITS with round-to-nearest.
    function automatic logic [COEF_BITS-1:0] scale_coef(input int unsigned w8);
        return COEF_BITS'((w8 * (32'd1 << COEF_BITS) + 32'd128) / 32'd256);
    endfunction

    localparam logic [COEF_BITS-1:0] C601_R = scale_coef(77);
    localparam logic [COEF_BITS-1:0] C601_G = scale_coef(150);
    localparam logic [COEF_BITS-1:0] C601_B = scale_coef(29);
    localparam logic [COEF_BITS-1:0] C709_R = scale_coef(54);
    localparam logic [COEF_BITS-1:0] C709_G = scale_coef(183);
    localparam logic [COEF_BITS-1:0] C709_B = scale_coef(19);
    localparam logic [COEF_BITS-1:0] CAVG_R = scale_coef(85);
    localparam logic [COEF_BITS-1:0] CAVG_G = scale_coef(86);
    localparam logic [COEF_BITS-1:0] CAVG_B = scale_coef(85);

    localparam logic [SUM_W-1:0] ROUND_C  = SUM_W'(1) << (COEF_BITS - 1);
    localparam logic [SUM_W-1:0] GRAY_MAX = SUM_W'((64'd1 << OUT_BITS) - 64'd1);

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [OUT_BITS-1:0]   r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
    logic [1:0]            mode1_q, mode1_d;
    logic                  last1_q, last1_d, last2_q, last2_d, last3_q, last3_d;
    logic [PROD_W-1:0]     rp2_q, rp2_d, gp2_q, gp2_d, bp2_q, bp2_d;
    logic [OUT_BITS-1:0]   gray3_q, gray3_d;
`ifdef CUSTOM_COEF_EN
    logic [COEF_BITS-1:0]  cr1_q, cr1_d, cg1_q, cg1_d, cb1_q, cb1_d;
`endif

    logic                  load1_c, load2_c, load3_c, in_ready_c, take_c;
    logic [R_BITS-1:0]     r_in_c;
    logic [G_BITS-1:0]     g_in_c;
    logic [B_BITS-1:0]     b_in_c;
    logic [OUT_BITS-1:0]   r_exp_c, g_exp_c, b_exp_c;
    logic [COEF_BITS-1:0]  cr_c, cg_c, cb_c;
    logic [SUM_W-1:0]      sum_c, shifted_c;
    logic [OUT_BITS-1:0]   gray_c;

    assign r_in_c = in_px_rgb_i[PX_W-1 -: R_BITS];
    assign g_in_c = in_px_rgb_i[B_BITS +: G_BITS];
    assign b_in_c = in_px_rgb_i[B_BITS-1:0];

    // MSB-aligned bit replication: full-scale input maps to full-scale output.
    for (genvar i = 0; i < OUT_BITS; i++) begin : g_exp
        assign r_exp_c[OUT_BITS-1-i] = r_in_c[R_BITS-1-(i % R_BITS)];
        assign g_exp_c[OUT_BITS-1-i] = g_in_c[G_BITS-1-(i % G_BITS)];
        assign b_exp_c[OUT_BITS-1-i] = b_in_c[B_BITS-1-(i % B_BITS)];
    end

    always_comb begin
        load3_c    = !v3_q || out_ready_i;
        load2_c    = !v2_q || load3_c;
        load1_c    = !v1_q || load2_c;
        in_ready_c = (state_q == RUN) && load1_c;
        take_c     = in_valid_i && in_ready_c;
    end

    assign in_ready_o = in_ready_c;

    always_comb begin
        cr_c = C601_R;
        cg_c = C601_G;
        cb_c = C601_B;
        case (mode1_q)
            2'd1: begin cr_c = C709_R; cg_c = C709_G; cb_c = C709_B; end
            2'd2: begin cr_c = CAVG_R; cg_c = CAVG_G; cb_c = CAVG_B; end
`ifdef CUSTOM_COEF_EN
            2'd3: begin cr_c = cr1_q;  cg_c = cg1_q;  cb_c = cb1_q;  end
`endif
            default: ;
        endcase
    end

    // Sum is two bits wider than a product, so three products plus rounding never wrap.
    always_comb begin
        sum_c     = SUM_W'(rp2_q) + SUM_W'(gp2_q) + SUM_W'(bp2_q) + ROUND_C;
        shifted_c = sum_c >> COEF_BITS;
        gray_c    = (shifted_c > GRAY_MAX) ? '1 : OUT_BITS'(shifted_c);
    end

    always_comb begin
        state_d = state_q;
        v1_d = v1_q;     v2_d = v2_q;     v3_d = v3_q;
        r1_d = r1_q;     g1_d = g1_q;     b1_d = b1_q;
        mode1_d = mode1_q;
        last1_d = last1_q; last2_d = last2_q; last3_d = last3_q;
        rp2_d = rp2_q;   gp2_d = gp2_q;   bp2_d = bp2_q;
        gray3_d = gray3_q;
`ifdef CUSTOM_COEF_EN
        cr1_d = cr1_q;   cg1_d = cg1_q;   cb1_d = cb1_q;
`endif

        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (!start_i) state_d = DRAIN;
            DRAIN: begin
                if (start_i)                   state_d = RUN;
                else if (!(v1_q || v2_q || v3_q)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);

        if (load1_c) begin
            v1_d = take_c;
            if (take_c) begin
                r1_d = r_exp_c; g1_d = g_exp_c; b1_d = b_exp_c;
                mode1_d = in_mode_i;
                last1_d = in_last_i;
`ifdef CUSTOM_COEF_EN
                cr1_d = coef_r_i; cg1_d = coef_g_i; cb1_d = coef_b_i;
`endif
            end
        end
        if (load2_c) begin
            v2_d = v1_q;
            if (v1_q) begin
                rp2_d = PROD_W'(r1_q) * PROD_W'(cr_c);
                gp2_d = PROD_W'(g1_q) * PROD_W'(cg_c);
                bp2_d = PROD_W'(b1_q) * PROD_W'(cb_c);
                last2_d = last1_q;
            end
        end
        if (load3_c) begin
            v3_d = v2_q;
            if (v2_q) begin
                gray3_d = gray_c;
                last3_d = last2_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            v1_q <= 1'b0;  v2_q <= 1'b0;  v3_q <= 1'b0;
            r1_q <= '0;    g1_q <= '0;    b1_q <= '0;
            mode1_q <= '0;
            last1_q <= 1'b0; last2_q <= 1'b0; last3_q <= 1'b0;
            rp2_q <= '0;   gp2_q <= '0;   bp2_q <= '0;
            gray3_q <= '0;
`ifdef CUSTOM_COEF_EN
            cr1_q <= '0;   cg1_q <= '0;   cb1_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            v1_q <= v1_d;  v2_q <= v2_d;  v3_q <= v3_d;
            r1_q <= r1_d;  g1_q <= g1_d;  b1_q <= b1_d;
            mode1_q <= mode1_d;
            last1_q <= last1_d; last2_q <= last2_d; last3_q <= last3_d;
            rp2_q <= rp2_d; gp2_q <= gp2_d; bp2_q <= bp2_d;
            gray3_q <= gray3_d;
`ifdef CUSTOM_COEF_EN
            cr1_q <= cr1_d; cg1_q <= cg1_d; cb1_q <= cb1_d;
`endif
        end
    end

    assign out_valid_o   = v3_q;
    assign out_px_gray_o = gray3_q;
    assign out_last_o    = last3_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_gray_scale_pipe.sv
// Scoreboard bench for gray_scale_pipe (RGB555 -> 8-bit gray, 8-bit coefficients).
module tb_gray_scale_pipe;

    logic        clk_i = 1'b0;
    logic        reset_i, start_i, in_valid_i, in_ready_o, in_last_i;
    logic [14:0] in_px_rgb_i;
    logic [1:0]  in_mode_i;
    logic        out_valid_o, out_ready_i, out_last_o, busy_o;
    logic [7:0]  out_px_gray_o;
`ifdef CUSTOM_COEF_EN
    logic [7:0]  coef_r_i, coef_g_i, coef_b_i;
`endif

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    logic [8:0] sb_q[$];
    logic [8:0] mon_exp;

    always #5 clk_i = ~clk_i;

    gray_scale_pipe dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_px_rgb_i(in_px_rgb_i),
        .in_mode_i(in_mode_i), .in_last_i(in_last_i),
`ifdef CUSTOM_COEF_EN
        .coef_r_i(coef_r_i), .coef_g_i(coef_g_i), .coef_b_i(coef_b_i),
`endif
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_px_gray_o(out_px_gray_o),
        .out_last_o(out_last_o), .busy_o(busy_o)
    );

    function automatic logic [7:0] model(input logic [14:0] px, input logic [1:0] mode);
        int r, g, b, cr, cg, cb, y;
        r = int'({px[14:10], px[14:12]});
        g = int'({px[9:5], px[9:7]});
        b = int'({px[4:0], px[4:2]});
        case (mode)
            2'd1:    begin cr = 54; cg = 183; cb = 19; end
            2'd2:    begin cr = 85; cg = 86;  cb = 85; end
            default: begin cr = 77; cg = 150; cb = 29; end
        endcase
        y = (r * cr + g * cg + b * cb + 128) >> 8;
        if (y > 255) y = 255;
        return 8'(y);
    endfunction

    // Output monitor: every taken output must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (!reset_i && out_valid_o && out_ready_i) begin
            out_cnt++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got gray=%0d last=%0b, required no output", out_px_gray_o, out_last_o);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({out_last_o, out_px_gray_o} !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_out: got gray=%0d last=%0b, required gray=%0d last=%0b",
                             out_px_gray_o, out_last_o, mon_exp[7:0], mon_exp[8]);
                end
            end
        end
    end

    // Present a pixel and hold it until accepted; returns just after the transfer edge.
    task automatic send_px(input logic [14:0] px, input logic [1:0] mode, input logic last,
                           input logic [7:0] exp, output int waited);
        bit done = 0;
        in_px_rgb_i = px; in_mode_i = mode; in_last_i = last; in_valid_i = 1'b1;
        waited = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                sb_q.push_back({last, exp});
                done = 1;
            end else begin
                waited++;
            end
            @(posedge clk_i); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready_o=0 for 20 cycles, required acceptance");
        end
    endtask

    task automatic wait_empty(input string name);
        bit done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(posedge clk_i); #2;
            if (sb_q.size() == 0) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: got %0d outputs outstanding, required 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; in_px_rgb_i = '0;
        in_mode_i = '0; in_last_i = 1'b0; out_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks += 5;
        if (out_valid_o !== 1'b0)   begin errors++; $display("FAIL rst_valid: got %b, required 0", out_valid_o); end
        if (out_px_gray_o !== 8'd0) begin errors++; $display("FAIL rst_gray: got %0d, required 0", out_px_gray_o); end
        if (out_last_o !== 1'b0)    begin errors++; $display("FAIL rst_last: got %b, required 0", out_last_o); end
        if (busy_o !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b, required 0", busy_o); end
        if (in_ready_o !== 1'b0)    begin errors++; $display("FAIL rst_ready: got %b, required 0", in_ready_o); end
        reset_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    // Pixel presented in the cycle after edge N must show out_valid_o after edge N+3.
    task automatic test_mode0();
        logic [14:0] px [5] = '{15'h7FFF, 15'h7C00, 15'h03E0, 15'h001F, 15'h0000};
        logic [7:0]  ex [5] = '{8'd255, 8'd77, 8'd149, 8'd29, 8'd0};
        int w;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        for (int i = 0; i < 5; i++) begin
            send_px(px[i], 2'd0, (i == 4), ex[i], w);
            checks++;
            if (w != 0) begin errors++; $display("FAIL m0_stall_%0d: got %0d wait cycles, required 0", i, w); end
            if (i < 2) begin
                checks++;
                if (out_valid_o !== 1'b0) begin errors++; $display("FAIL m0_early_%0d: got out_valid_o=%b, required 0", i, out_valid_o); end
            end else if (i == 2) begin
                checks++;
                if (out_valid_o !== 1'b1 || out_px_gray_o !== 8'd255) begin
                    errors++;
                    $display("FAIL m0_latency: got valid=%b gray=%0d, required valid=1 gray=255", out_valid_o, out_px_gray_o);
                end
            end
        end
        in_valid_i = 1'b0;
        wait_empty("mode0");
    endtask

    task automatic test_modes();
        int w;
        send_px(15'h7C00, 2'd1, 1'b0, 8'd54,  w);
        send_px(15'h03E0, 2'd1, 1'b0, 8'd182, w);
        send_px(15'h7FFF, 2'd2, 1'b1, 8'd255, w);
        send_px(15'h7C00, 2'd0, 1'b0, 8'd77,  w);
        in_valid_i = 1'b0;
        wait_empty("modes");
    endtask

    task automatic test_stall();
        fork
            begin
                logic [14:0] p;
                logic [1:0]  m;
                logic        l;
                int          w;
                for (int k = 0; k < 10; k++) begin
                    p = 15'($urandom);
                    m = 2'($urandom_range(0, 2));
                    l = 1'($urandom);
                    send_px(p, m, l, model(p, m), w);
                end
                in_valid_i = 1'b0;
            end
            begin
                logic       cv, cl;
                logic [7:0] cg;
                repeat (4) @(posedge clk_i);
                #2;
                cv = out_valid_o; cg = out_px_gray_o; cl = out_last_o;
                checks++;
                if (cv !== 1'b1) begin errors++; $display("FAIL stall_start: got out_valid_o=%b, required 1", cv); end
                out_ready_i = 1'b0;
                repeat (4) begin
                    @(posedge clk_i); #2;
                    checks++;
                    if (out_valid_o !== cv || out_px_gray_o !== cg || out_last_o !== cl) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b g=%0d l=%b, required v=%b g=%0d l=%b",
                                 out_valid_o, out_px_gray_o, out_last_o, cv, cg, cl);
                    end
                end
                out_ready_i = 1'b1;
            end
        join
        wait_empty("stall");
    endtask

    task automatic test_drain();
        int  w;
        bit  empty = 0;
        bit  fell = 0;
        send_px(15'h7C00, 2'd0, 1'b0, 8'd77,  w);
        send_px(15'h03E0, 2'd0, 1'b0, 8'd149, w);
        start_i = 1'b0;
        send_px(15'h001F, 2'd0, 1'b1, 8'd29,  w);
        in_px_rgb_i = 15'h7FFF;
        checks += 2;
        if (in_ready_o !== 1'b0) begin errors++; $display("FAIL drain_ready: got %b, required 0", in_ready_o); end
        if (busy_o !== 1'b1)     begin errors++; $display("FAIL drain_busy: got %b, required 1", busy_o); end
        for (int k = 0; k < 20 && !empty; k++) begin
            @(posedge clk_i); #2;
            checks++;
            if (in_ready_o !== 1'b0) begin errors++; $display("FAIL drain_ready_hold: got %b, required 0", in_ready_o); end
            if (sb_q.size() == 0) empty = 1;
        end
        checks++;
        if (!empty || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL drain_last: got empty=%0b busy=%b, required empty=1 busy=1", empty, busy_o);
        end
        for (int k = 0; k < 3 && !fell; k++) begin
            @(posedge clk_i); #2;
            if (busy_o === 1'b0) fell = 1;
        end
        checks++;
        if (!fell) begin errors++; $display("FAIL drain_idle: got busy_o=%b, required 0", busy_o); end
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int w;
        int cnt0;
        start_i = 1'b1; out_ready_i = 1'b0;
        @(posedge clk_i); #1;
        send_px(15'h7FFF, 2'd0, 1'b0, 8'd255, w);
        send_px(15'h7C00, 2'd0, 1'b0, 8'd77,  w);
        send_px(15'h03E0, 2'd0, 1'b1, 8'd149, w);
        in_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1) begin errors++; $display("FAIL rmid_full: got out_valid_o=%b, required 1", out_valid_o); end
        reset_i = 1'b1;
        sb_q.delete();
        @(posedge clk_i); #1;
        checks += 2;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b, required 0", out_valid_o); end
        if (busy_o !== 1'b0)      begin errors++; $display("FAIL rmid_busy: got %b, required 0", busy_o); end
        reset_i = 1'b0; start_i = 1'b0; out_ready_i = 1'b1;
        cnt0 = out_cnt;
        repeat (10) @(posedge clk_i);
        #1;
        checks++;
        if (out_cnt != cnt0) begin errors++; $display("FAIL rmid_quiet: got %0d outputs, required 0", out_cnt - cnt0); end
    endtask

    task automatic test_custom();
        int w;
        logic [7:0] exp_c;
`ifdef CUSTOM_COEF_EN
        coef_r_i = 8'd0; coef_g_i = 8'd0; coef_b_i = 8'd255;
        exp_c = 8'd254;
`else
        exp_c = 8'd29;
`endif
        start_i = 1'b1;
        @(posedge clk_i); #1;
        send_px(15'h001F, 2'd3, 1'b1, exp_c, w);
        in_valid_i = 1'b0;
        wait_empty("custom");
        start_i = 1'b0;
    endtask

    initial begin
`ifdef CUSTOM_COEF_EN
        coef_r_i = '0; coef_g_i = '0; coef_b_i = '0;
`endif
        test_reset();
        test_mode0();
        test_modes();
        test_stall();
        test_drain();
        test_reset_mid();
        test_custom();
        repeat (5) @(posedge clk_i);
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL final_sb: got %0d pending, required 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required $finish");
        $fatal(1, "watchdog");
    end

endmodule
